// File: rtl/serial_sub_ctrl.sv
`default_nettype none
// ==========================================================================
// serial_sub_ctrl : bit-serial unsigned subtractor sequencer, LSB first  (rev 1.0)
// ==========================================================================
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Full subtractor: two half subtractors, borrows ORed together
  logic w_hs_d, w_cell_d, w_cell_bout;
  assign w_hs_d      = a_q[0] ^ b_q[0];
  assign w_cell_d    = w_hs_d ^ br_q;
  assign w_cell_bout = (~a_q[0] & b_q[0]) | (~w_hs_d & br_q);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          a_d     = a_i;
          b_d     = b_i;
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {w_cell_d, res_q[WIDTH-1:1]};
        br_d  = w_cell_bout;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == C_LAST) begin
          state_d  = DONE;
          diff_d   = {w_cell_d, res_q[WIDTH-1:1]};
          borrow_d = w_cell_bout;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy_o   = (state_q == RUN);
  assign done_o   = (state_q == DONE);
  assign diff_o   = diff_q;
  assign borrow_o = borrow_q;

endmodule
`default_nettype wire
